// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped, write-back data cache:
//   - address field widths (tag / index / offset) and block width
//   - cache controller state encoding
//   - load/store opcodes shared with the control unit
//   - byte select / byte merge helpers used by the cache storage
// ---------------------------------------------------------------------------
package dcache_pkg;

  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int TAG_W       = 3;
  localparam int INDEX_W     = 3;
  localparam int OFFSET_W    = 2;
  localparam int BLOCK_W     = 32;
  localparam int MEM_ADDR_W  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Memory-access opcodes, kept in step with the control unit decoder.
  localparam logic [7:0] OP_LWD = 8'h0E;
  localparam logic [7:0] OP_LWI = 8'h0F;
  localparam logic [7:0] OP_SWD = 8'h10;
  localparam logic [7:0] OP_SWI = 8'h11;

  // Pick one byte out of a block; offset 0 is the least significant byte.
  function automatic logic [7:0] sel_byte(input logic [BLOCK_W-1:0]  blk,
                                          input logic [OFFSET_W-1:0] off);
    case (off)
      2'd0:    sel_byte = blk[7:0];
      2'd1:    sel_byte = blk[15:8];
      2'd2:    sel_byte = blk[23:16];
      2'd3:    sel_byte = blk[31:24];
      default: sel_byte = blk[7:0];
    endcase
  endfunction

  // Replace one byte of a block, leaving the other three untouched.
  function automatic logic [BLOCK_W-1:0] merge_byte(input logic [BLOCK_W-1:0]  blk,
                                                    input logic [OFFSET_W-1:0] off,
                                                    input logic [7:0]          b);
    merge_byte = blk;
    case (off)
      2'd0:    merge_byte[7:0]   = b;
      2'd1:    merge_byte[15:8]  = b;
      2'd2:    merge_byte[23:16] = b;
      2'd3:    merge_byte[31:24] = b;
      default: merge_byte[7:0]   = b;
    endcase
  endfunction

endpackage

// File: rtl/dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array
// Tag / valid / dirty / data storage for the data cache. Reads are
// combinational on i_index; writes happen on the rising clock edge.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset (clears valid/dirty)
//   i_index          line being read and written
//   i_fill_en        write a whole line (tag, data, valid=1, dirty=0)
//   i_fill_tag/data  line contents for a fill
//   i_byte_en        store one byte into the line and mark it dirty
//   i_offset/i_byte  byte position and value for a store
//   o_valid/o_dirty/o_tag/o_data  current contents of line i_index
// ---------------------------------------------------------------------------
module dcache_array
  import dcache_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [INDEX_W-1:0]  i_index,
  input  logic                i_fill_en,
  input  logic [TAG_W-1:0]    i_fill_tag,
  input  logic [BLOCK_W-1:0]  i_fill_data,
  input  logic                i_byte_en,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic [7:0]          i_byte,
  output logic                o_valid,
  output logic                o_dirty,
  output logic [TAG_W-1:0]    o_tag,
  output logic [BLOCK_W-1:0]  o_data
);

  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

  // Line status bits: reset invalidates every line, fills and stores update one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= {NUM_BLOCKS{1'b0}};
      r_dirty <= {NUM_BLOCKS{1'b0}};
    end else if (i_fill_en) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_byte_en) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  // Tag and data payload; contents are don't-care until the valid bit is set.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_fill_en) begin
      r_tag[i_index]  <= i_fill_tag;
      r_data[i_index] <= i_fill_data;
    end else if (i_rst_n && i_byte_en) begin
      r_data[i_index] <= merge_byte(r_data[i_index], i_offset, i_byte);
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_data  = r_data[i_index];

endmodule

// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-back data cache (8 lines x 4 bytes) between the CPU
// datapath and a 32-bit-block data memory.
// CPU side:    CLK, RESET (sync, active low), READ, WRITE, ADDRESS,
//              WRITEDATA -> READDATA, BUSYWAIT (stall)
// Memory side: mem_read, mem_write, mem_address, mem_writedata (registered)
//              <- mem_readdata, mem_busywait
// Build option: define DCACHE_STATS_EN to add hit_count / miss_count
// outputs (16-bit, saturating, cleared by reset).
// ---------------------------------------------------------------------------
module data_cache
  import dcache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [7:0]            ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]    mem_writedata,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [MEM_ADDR_W-1:0] r_mem_address;
  logic [BLOCK_W-1:0]    r_mem_writedata;
  logic [BLOCK_W-1:0]    r_fill;
  logic [7:0]            r_readdata;

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_W-1:0]    w_index;
  logic [OFFSET_W-1:0]   w_offset;
  logic                  w_valid;
  logic                  w_dirty;
  logic [TAG_W-1:0]      w_stored_tag;
  logic [BLOCK_W-1:0]    w_line;
  logic                  w_hit;
  logic                  w_req;
  logic                  w_rd_hit;
  logic                  w_wr_hit;

  assign w_tag    = ADDRESS[7:5];
  assign w_index  = ADDRESS[4:2];
  assign w_offset = ADDRESS[1:0];
  assign w_hit    = w_valid && (w_stored_tag == w_tag);
  assign w_req    = READ || WRITE;
  // WRITE wins when both strobes are high, so a read hit needs WRITE low.
  assign w_rd_hit = (r_state == IDLE) && READ && !WRITE && w_hit;
  assign w_wr_hit = (r_state == IDLE) && WRITE && w_hit;

  dcache_array u_array (
    .i_clk       (CLK),
    .i_rst_n     (RESET),
    .i_index     (w_index),
    .i_fill_en   (r_state == UPDATE),
    .i_fill_tag  (w_tag),
    .i_fill_data (r_fill),
    .i_byte_en   (w_wr_hit),
    .i_offset    (w_offset),
    .i_byte      (WRITEDATA),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_stored_tag),
    .o_data      (w_line)
  );

  // Controller next-state: a miss evicts a dirty line before fetching.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          if (w_dirty) begin
            w_next_state = WRITEBACK;
          end else begin
            w_next_state = FETCH;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_busywait) begin
          w_next_state = WRITEBACK;
        end else begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        if (mem_busywait) begin
          w_next_state = FETCH;
        end else begin
          w_next_state = UPDATE;
        end
      end
      UPDATE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State, memory strobes (registered from the next state so mem_busywait
  // never loops back combinationally), fill buffer and last load byte.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state         <= IDLE;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= {MEM_ADDR_W{1'b0}};
      r_mem_writedata <= {BLOCK_W{1'b0}};
      r_fill          <= {BLOCK_W{1'b0}};
      r_readdata      <= 8'h00;
    end else begin
      r_state     <= w_next_state;
      r_mem_read  <= (w_next_state == FETCH);
      r_mem_write <= (w_next_state == WRITEBACK);
      case (w_next_state)
        WRITEBACK: begin
          r_mem_address   <= {w_stored_tag, w_index};
          r_mem_writedata <= w_line;
        end
        FETCH: begin
          r_mem_address   <= ADDRESS[7:2];
          r_mem_writedata <= {BLOCK_W{1'b0}};
        end
        default: begin
          r_mem_address   <= {MEM_ADDR_W{1'b0}};
          r_mem_writedata <= {BLOCK_W{1'b0}};
        end
      endcase
      if ((r_state == FETCH) && !mem_busywait) begin
        r_fill <= mem_readdata;
      end
      if (w_rd_hit) begin
        r_readdata <= sel_byte(w_line, w_offset);
      end
    end
  end

  // CPU-facing outputs: a read hit is served in the same cycle, otherwise
  // the last loaded byte is held.
  always_comb begin
    READDATA = r_readdata;
    BUSYWAIT = 1'b1;
    if (w_rd_hit) begin
      READDATA = sel_byte(w_line, w_offset);
    end else begin
      READDATA = r_readdata;
    end
    if (r_state == IDLE) begin
      BUSYWAIT = w_req && !w_hit;
    end else begin
      BUSYWAIT = 1'b1;
    end
  end

  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;

`ifdef DCACHE_STATS_EN
  logic        r_pending;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  // Count each request once, on its first IDLE cycle; r_pending marks the
  // re-check after a fill so it is not counted again as a hit.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pending    <= 1'b0;
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else if ((r_state == IDLE) && w_req) begin
      if (r_pending) begin
        r_pending <= !w_hit;
      end else if (w_hit) begin
        if (r_hit_count != 16'hFFFF) begin
          r_hit_count <= r_hit_count + 16'h0001;
        end
      end else begin
        r_pending <= 1'b1;
        if (r_miss_count != 16'hFFFF) begin
          r_miss_count <= r_miss_count + 16'h0001;
        end
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_data_cache.sv
// ---------------------------------------------------------------------------
// tb_data_cache
// Self-checking bench for data_cache: a latency-programmable block memory,
// a line-level reference model of the cache, directed scenarios and a
// randomized request stream.
// ---------------------------------------------------------------------------
module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Block memory: each transaction keeps mem_busywait high for 'lat' cycles.
  logic [31:0] mem_arr [64];
  int          mem_cnt = 0;
  int          lat = 0;
  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < lat);
  assign mem_readdata = mem_arr[mem_address];

  always @(posedge CLK) begin
    if (mem_read || mem_write) begin
      if (mem_busywait) begin
        mem_cnt <= mem_cnt + 1;
      end else begin
        mem_cnt <= 0;
        if (mem_write) mem_arr[mem_address] = mem_writedata;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // Reference model: cache lines, backing memory, last load byte, counters.
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  logic [31:0] ref_mem [64];
  logic [7:0]  m_last_rd;
  int          m_hits, m_misses;

  int          tests = 0;
  int          fails = 0;
  logic [5:0]  obs_wb_addr, obs_fetch_addr;
  logic [31:0] obs_wb_data;
  logic [7:0]  obs_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_last_rd = 8'h00;
    m_hits    = 0;
    m_misses  = 0;
  endtask

  // One CPU request, held until BUSYWAIT drops, checked against the model.
  task automatic do_req(input bit wr, input bit both, input logic [7:0] addr, input logic [7:0] wd);
    int          idx, sh, stall_exp, cyc, rd_cyc, wr_cyc;
    bit          hit, wb;
    logic [5:0]  wb_addr, f_addr;
    logic [31:0] wb_data;
    logic [7:0]  exp_rd;
    idx     = int'(addr[4:2]);
    sh      = 8 * int'(addr[1:0]);
    hit     = m_valid[idx] && (m_tag[idx] == addr[7:5]);
    wb      = !hit && m_dirty[idx];
    wb_addr = {m_tag[idx], addr[4:2]};
    wb_data = m_data[idx];
    f_addr  = addr[7:2];
    if (hit) m_hits++; else m_misses++;
    if (!hit) begin
      if (wb) ref_mem[wb_addr] = m_data[idx];
      m_data[idx]  = ref_mem[f_addr];
      m_tag[idx]   = addr[7:5];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    stall_exp = hit ? 0 : (lat + 3 + (wb ? lat + 1 : 0));

    READ = !wr || both; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    #1;
    check("busy_first", BUSYWAIT, !hit);
    cyc = 0; rd_cyc = 0; wr_cyc = 0;
    while (BUSYWAIT === 1'b1 && cyc < 100) begin
      check("strobe_excl", mem_read & mem_write, 1'b0);
      if (mem_write === 1'b1) begin
        wr_cyc++;
        obs_wb_addr = mem_address;
        obs_wb_data = mem_writedata;
        check("wb_addr", mem_address, wb_addr);
        check("wb_data", mem_writedata, wb_data);
      end
      if (mem_read === 1'b1) begin
        rd_cyc++;
        obs_fetch_addr = mem_address;
        check("fetch_addr", mem_address, f_addr);
      end
      cyc++;
      @(posedge CLK); #3;
    end
    check("stall_cycles", cyc, stall_exp);
    check("fetch_cycles", rd_cyc, hit ? 0 : lat + 1);
    check("wb_cycles", wr_cyc, wb ? lat + 1 : 0);
    check("idle_strobes", {mem_read, mem_write}, 2'b00);
    if (wr) begin
      m_data[idx]  = (m_data[idx] & ~(32'hFF << sh)) | ({24'h0, wd} << sh);
      m_dirty[idx] = 1'b1;
    end else begin
      exp_rd    = 8'((m_data[idx] >> sh) & 32'hFF);
      obs_rd    = READDATA;
      check("readdata", READDATA, exp_rd);
      m_last_rd = exp_rd;
    end
    @(posedge CLK); #2;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic idle_cycle();
    READ = 1'b0; WRITE = 1'b0;
    #1;
    check("hold_readdata", READDATA, m_last_rd);
    check("idle_busy", BUSYWAIT, 1'b0);
    @(posedge CLK); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int          cyc;
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    obs_wb_addr = 6'h00; obs_wb_data = 32'h0; obs_fetch_addr = 6'h00; obs_rd = 8'h00;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[1] = 32'hDDCCBBAA;
    ref_mem[1] = 32'hDDCCBBAA;
    model_reset();
    lat = 2;
    repeat (2) @(posedge CLK);
    #2;
    check("rst_readdata", READDATA, 8'h00);
    check("rst_busy", BUSYWAIT, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_address, 6'h00);
    RESET = 1'b1;

    // Fill on read miss, then an immediate hit.
    do_req(1'b0, 1'b0, 8'h05, 8'h00);
    check("tp_fetch_addr", obs_fetch_addr, 6'h01);
    check("tp_read_bb", obs_rd, 8'hBB);
    do_req(1'b0, 1'b0, 8'h05, 8'h00);
    // Store hit, then load it back.
    do_req(1'b1, 1'b0, 8'h05, 8'h5A);
    do_req(1'b0, 1'b0, 8'h05, 8'h00);
    check("tp_read_5a", obs_rd, 8'h5A);
    idle_cycle();
    // Dirty eviction.
    do_req(1'b0, 1'b0, 8'hA5, 8'h00);
    check("tp_wb_addr", obs_wb_addr, 6'h01);
    check("tp_wb_data", obs_wb_data, 32'hDDCC5AAA);
    check("tp_fetch_addr2", obs_fetch_addr, 6'h29);

    // Long memory latency.
    lat = 5;
    do_req(1'b0, 1'b0, 8'h10, 8'h00);
    do_req(1'b1, 1'b0, 8'h11, 8'h77);

    // Reset while a writeback is in progress.
    READ = 1'b1; ADDRESS = 8'h30;
    cyc = 0;
    while (mem_write !== 1'b1 && cyc < 20) begin
      @(posedge CLK); #2;
      cyc++;
    end
    check("rst_reach_wb", mem_write, 1'b1);
    RESET = 1'b0; READ = 1'b0;
    @(posedge CLK); #2;
    check("rstwb_mem_write", mem_write, 1'b0);
    check("rstwb_mem_read", mem_read, 1'b0);
    check("rstwb_busy", BUSYWAIT, 1'b0);
    RESET = 1'b1;
    model_reset();
`ifdef DCACHE_STATS_EN
    check("stats_rst_hit", hit_count, 16'h0000);
    check("stats_rst_miss", miss_count, 16'h0000);
`endif
    lat = 1;
    do_req(1'b0, 1'b0, 8'h05, 8'h00);
    do_req(1'b0, 1'b0, 8'h05, 8'h00);
    do_req(1'b0, 1'b0, 8'h06, 8'h00);
    do_req(1'b0, 1'b0, 8'hA5, 8'h00);
`ifdef DCACHE_STATS_EN
    check("stats_hit_2", hit_count, 16'h0002);
    check("stats_miss_2", miss_count, 16'h0002);
`endif

    // Randomized stream over a few tags so hits, misses and evictions mix.
    for (int n = 0; n < 150; n++) begin
      bit wr, both;
      r    = $urandom;
      lat  = int'($urandom_range(0, 3));
      wr   = (r[10:9] == 2'b00);
      both = wr && (r[13:11] == 3'b000);
      do_req(wr, both, {1'b0, r[6:0]}, r[23:16]);
      if (r[26:24] == 3'b000) idle_cycle();
    end

`ifdef DCACHE_STATS_EN
    check("stats_hits", hit_count, 16'(m_hits));
    check("stats_misses", miss_count, 16'(m_misses));
`endif
    for (int i = 0; i < 64; i++) begin
      check("mem_image", mem_arr[i], ref_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back data cache between the CPU datapath and the 32-bit-block data memory.
- Consumes the mem_read/mem_write strobes from the control unit, the ALU result (address) and the register-file OUT1 (store data).
- Returns the load data and a BUSYWAIT stall that freezes the PC and the register write until the access completes.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; index width is log2(NUM_BLOCKS), i.e. 3.
- BLOCK_BYTES, 4, bytes per line; offset width is 2, tag width is 8-3-2 = 3.

Ports:
CLK  in  1  system clock, all state updates on rising edge
RESET  in  1  synchronous, active-low reset
READ  in  1  load request (control-unit mem_read)
WRITE  in  1  store request (control-unit mem_write)
ADDRESS  in  8  byte address {tag[7:5], index[4:2], offset[1:0]}
WRITEDATA  in  8  store byte
READDATA  out  8  load byte
BUSYWAIT  out  1  stall to CPU
mem_read  out  1  block read request to memory
mem_write  out  1  block write request to memory
mem_address  out  6  block address {tag, index}
mem_writedata  out  32  block being written back
mem_readdata  in  32  block returned by memory
mem_busywait  in  1  memory busy; low means transaction complete

Behaviour:
- Reset (RESET low at an edge): all valid and dirty bits cleared; state IDLE; mem_read, mem_write, BUSYWAIT, READDATA = 0; mem_address = 0.
- Per line: valid, dirty, 3-bit tag, 32-bit data. Byte select: offset 0 = bits [7:0] through offset 3 = bits [31:24].
- hit = valid[index] && (tag[index] == ADDRESS[7:5]), combinational.
- IDLE, READ hit: READDATA = selected byte combinationally, BUSYWAIT = 0, zero stall cycles.
- IDLE, WRITE hit: byte written at the next edge and dirty set; BUSYWAIT = 0.
- IDLE, READ or WRITE miss: BUSYWAIT = 1 combinationally in the same cycle.
  - Next state is WRITEBACK if dirty[index] is set, otherwise FETCH.
- READ and WRITE both high is illegal; WRITE takes priority.
- No request: BUSYWAIT = 0 and READDATA holds its last value.
- WRITEBACK:
  - mem_write = 1, mem_address = {stored tag, index}, mem_writedata = line data.
  - Stays in WRITEBACK while mem_busywait = 1.
  - First edge with mem_busywait = 0 moves to FETCH.
- FETCH:
  - mem_read = 1, mem_address = ADDRESS[7:2].
  - Stays while mem_busywait = 1.
  - First edge with mem_busywait = 0 captures mem_readdata and moves to UPDATE.
- UPDATE:
  - Writes data, tag, valid = 1, dirty = 0 into the line; moves to IDLE.
  - The request then re-evaluates in IDLE as a hit.
  - A store completes there: line marked dirty, BUSYWAIT drops.
- BUSYWAIT = 1 in WRITEBACK, FETCH and UPDATE.
- mem_read and mem_write are never high together. Both are 0 in IDLE and UPDATE.
- Miss cost: UPDATE (1 cycle) + IDLE re-check, plus one FETCH period, plus one WRITEBACK period when the line is dirty.
- ADDRESS, WRITEDATA, READ and WRITE are held stable by the CPU while BUSYWAIT = 1; the cache does not latch them.
- RESET low mid-transaction:
  - The transaction is abandoned; next state is IDLE and memory strobes drop.
  - Dirty data is lost, which is acceptable.
- Outputs driving memory are registered from the state, so there are no combinational loops through mem_busywait.

Optional Feature:
- DCACHE_STATS_EN defined: adds output ports hit_count (16) and miss_count (16).
  - Each increments once per completed request, evaluated in IDLE on the first cycle of the request only.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package dcache_pkg holds:
  - Width constants: TAG_W = 3, INDEX_W = 3, OFFSET_W = 2, BLOCK_W = 32.
  - State enum: IDLE, WRITEBACK, FETCH, UPDATE.
  - Opcode constants for lwd/lwi/swd/swi shared with the control unit.
- One sub-module, dcache_array: the tag/valid/dirty/data storage with synchronous write and combinational read.
- The FSM stays in data_cache.

Test Plan:
- Reset, then READ at ADDRESS 8'h05 with memory block 2'h01 = 32'hDDCCBBAA:
  - Miss, FETCH with mem_address 6'h01, READDATA = 8'hBB.
  - BUSYWAIT then drops; an immediate repeat read hits with no stall.
- WRITE 8'h5A to 8'h05 after that fill:
  - Hit, no stall, line dirty.
  - A subsequent READ of 8'h05 returns 8'h5A.
- READ at 8'hA5 (same index 1, tag 5) with dirty line tag 0:
  - WRITEBACK first, mem_address 6'h01, mem_writedata 32'hDDCC5AAA.
  - Then FETCH with mem_address 6'h29.
- mem_busywait held high for 5 cycles in FETCH:
  - BUSYWAIT stays 1 and mem_read stays 1 throughout.
  - Completion occurs exactly one edge after mem_busywait falls.
- RESET pulled low during WRITEBACK:
  - Next cycle mem_write = 0 and BUSYWAIT = 0.
  - Read of 8'h05 misses, since valid was cleared.
- With DCACHE_STATS_EN: sequence miss, hit, hit, miss -> hit_count = 2, miss_count = 2.
